// File: rtl/spi_flash_arbiter.sv
// Shares one SPI flash between the DSP SPI port and CPU SPI1: one owner per
// chip-select transaction, a guard gap between owners, and a hold timeout.
module spi_flash_arbiter #(
  parameter int unsigned            GUARD_CYCLES = 4,
  parameter int unsigned            TIMER_WIDTH  = 20,
  parameter logic [TIMER_WIDTH-1:0] HOLD_LIMIT   = 20'hFFFFF
) (
  input  logic sysclk,
  input  logic reset_INV,
  input  logic dsp_en,
  input  logic dsp_cs_INV,
  input  logic dsp_clk,
  input  logic dsp_mosi,
  output logic dsp_miso,
  input  logic cpu_cs_INV,
  input  logic cpu_clk,
  input  logic cpu_mosi,
  output logic cpu_miso,
  output logic flash_cs_INV,
  output logic flash_clk,
  output logic flash_mosi,
  input  logic flash_miso,
  output logic dsp_busy,
  output logic cpu_busy,
  output logic dsp_fault,
  output logic cpu_fault
);

  localparam int unsigned GUARD_EFF = (GUARD_CYCLES == 0) ? 1 : GUARD_CYCLES;
  localparam int unsigned GW        = $clog2(GUARD_EFF + 1);
  localparam logic [GW-1:0]          GUARD_LAST = GW'(GUARD_EFF - 1);
  localparam logic [GW-1:0]          GUARD_ONE  = GW'(1);
  localparam logic [TIMER_WIDTH:0]   HOLD_ONE   = (TIMER_WIDTH+1)'(1);
  localparam logic [TIMER_WIDTH:0]   HOLD_MAX   = {1'b0, HOLD_LIMIT};

  typedef enum logic [1:0] {IDLE, OWN_DSP, OWN_CPU, GUARD} state_t;

  state_t                 state;
  logic                   last_cpu;
  logic [TIMER_WIDTH-1:0] hold_cnt;
  logic [GW-1:0]          guard_cnt;
  logic                   dsp_lock, cpu_lock;
  logic                   dsp_busy_r, cpu_busy_r;

  logic dsp_cs_p0, dsp_cs_p1, dsp_cs_p2;
  logic cpu_cs_p0, cpu_cs_p1, cpu_cs_p2;
  logic vld_p0, vld_p1, vld_p2;

  // Stage p0/p1: 2-flop CS synchronisers; p2 holds the previous synchronised
  // value. vld_pN marks each stage as holding a real post-reset sample, so a
  // CS held low across reset never looks like a fresh falling edge.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      dsp_cs_p0 <= 1'b1;
      dsp_cs_p1 <= 1'b1;
      dsp_cs_p2 <= 1'b1;
      cpu_cs_p0 <= 1'b1;
      cpu_cs_p1 <= 1'b1;
      cpu_cs_p2 <= 1'b1;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
    end else begin
      dsp_cs_p0 <= dsp_cs_INV;
      dsp_cs_p1 <= dsp_cs_p0;
      dsp_cs_p2 <= dsp_cs_p1;
      cpu_cs_p0 <= cpu_cs_INV;
      cpu_cs_p1 <= cpu_cs_p0;
      cpu_cs_p2 <= cpu_cs_p1;
      vld_p0    <= 1'b1;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
    end
  end

  logic dsp_req, cpu_req;
  logic [TIMER_WIDTH:0] hold_nx;
  logic hold_over;

  assign dsp_req   = vld_p2 & dsp_cs_p2 & ~dsp_cs_p1 & dsp_en & ~dsp_lock;
  assign cpu_req   = vld_p2 & cpu_cs_p2 & ~cpu_cs_p1 & ~cpu_lock;
  assign hold_nx   = {1'b0, hold_cnt} + HOLD_ONE;
  assign hold_over = (hold_nx >= HOLD_MAX);

  // Stage p3: ownership state, lockouts and sticky faults
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      state      <= IDLE;
      last_cpu   <= 1'b1;
      hold_cnt   <= '0;
      guard_cnt  <= '0;
      dsp_lock   <= 1'b0;
      cpu_lock   <= 1'b0;
      dsp_fault  <= 1'b0;
      cpu_fault  <= 1'b0;
      dsp_busy_r <= 1'b0;
      cpu_busy_r <= 1'b0;
    end else begin
      dsp_busy_r <= (state == OWN_CPU) || (state == GUARD);
      cpu_busy_r <= (state == OWN_DSP) || (state == GUARD);
      if (dsp_cs_p1) dsp_lock <= 1'b0;
      if (cpu_cs_p1) cpu_lock <= 1'b0;
      case (state)
        IDLE: begin
          hold_cnt  <= '0;
          guard_cnt <= '0;
          if (dsp_req && cpu_req) begin
            if (last_cpu) begin
              state     <= OWN_DSP;
              cpu_fault <= 1'b1;
              cpu_lock  <= 1'b1;
            end else begin
              state     <= OWN_CPU;
              dsp_fault <= 1'b1;
              dsp_lock  <= 1'b1;
            end
          end else if (dsp_req) begin
            state <= OWN_DSP;
          end else if (cpu_req) begin
            state <= OWN_CPU;
          end
        end
        OWN_DSP: begin
          hold_cnt <= hold_nx[TIMER_WIDTH-1:0];
          if (cpu_req) begin
            cpu_fault <= 1'b1;
            cpu_lock  <= 1'b1;
          end
          if (dsp_cs_p1) begin
            last_cpu <= 1'b0;
            state    <= GUARD;
          end else if (hold_over || !dsp_en) begin
            dsp_fault <= 1'b1;
            dsp_lock  <= 1'b1;
            last_cpu  <= 1'b0;
            state     <= GUARD;
          end
        end
        OWN_CPU: begin
          hold_cnt <= hold_nx[TIMER_WIDTH-1:0];
          if (dsp_req) begin
            dsp_fault <= 1'b1;
            dsp_lock  <= 1'b1;
          end
          if (cpu_cs_p1) begin
            last_cpu <= 1'b1;
            state    <= GUARD;
          end else if (hold_over) begin
            cpu_fault <= 1'b1;
            cpu_lock  <= 1'b1;
            last_cpu  <= 1'b1;
            state     <= GUARD;
          end
        end
        GUARD: begin
          hold_cnt <= '0;
          if (dsp_req) begin
            dsp_fault <= 1'b1;
            dsp_lock  <= 1'b1;
          end
          if (cpu_req) begin
            cpu_fault <= 1'b1;
            cpu_lock  <= 1'b1;
          end
          if (guard_cnt == GUARD_LAST) begin
            guard_cnt <= '0;
            state     <= IDLE;
          end else begin
            guard_cnt <= guard_cnt + GUARD_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pin mux follows the registered owner so flash CS drops the instant reset hits
  always_comb begin
    flash_cs_INV = 1'b1;
    flash_clk    = 1'b0;
    flash_mosi   = 1'b0;
    dsp_miso     = 1'b0;
    cpu_miso     = 1'b0;
    case (state)
      OWN_DSP: begin
        flash_cs_INV = dsp_cs_INV;
        flash_clk    = dsp_clk;
        flash_mosi   = dsp_mosi;
        dsp_miso     = flash_miso;
      end
      OWN_CPU: begin
        flash_cs_INV = cpu_cs_INV;
        flash_clk    = cpu_clk;
        flash_mosi   = cpu_mosi;
        cpu_miso     = flash_miso;
      end
      default: ;
    endcase
  end

  assign dsp_busy = dsp_busy_r | ~dsp_en;
  assign cpu_busy = cpu_busy_r;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: behavioural ownership model checked every cycle,
// plus directed literal expectations for latency, guard, timeout and reset.
module tb_spi_flash_arbiter;

  localparam int GUARD = 4;
  localparam int HOLD  = 16;

  logic sysclk = 1'b0;
  logic reset_INV, dsp_en;
  logic dsp_cs_INV, dsp_clk, dsp_mosi, dsp_miso;
  logic cpu_cs_INV, cpu_clk, cpu_mosi, cpu_miso;
  logic flash_cs_INV, flash_clk, flash_mosi, flash_miso;
  logic dsp_busy, cpu_busy, dsp_fault, cpu_fault;

  int tests = 0;
  int fails = 0;

  always #5 sysclk = ~sysclk;

  spi_flash_arbiter #(
    .GUARD_CYCLES(GUARD),
    .TIMER_WIDTH (20),
    .HOLD_LIMIT  (20'd16)
  ) dut (
    .sysclk      (sysclk),
    .reset_INV   (reset_INV),
    .dsp_en      (dsp_en),
    .dsp_cs_INV  (dsp_cs_INV),
    .dsp_clk     (dsp_clk),
    .dsp_mosi    (dsp_mosi),
    .dsp_miso    (dsp_miso),
    .cpu_cs_INV  (cpu_cs_INV),
    .cpu_clk     (cpu_clk),
    .cpu_mosi    (cpu_mosi),
    .cpu_miso    (cpu_miso),
    .flash_cs_INV(flash_cs_INV),
    .flash_clk   (flash_clk),
    .flash_mosi  (flash_mosi),
    .flash_miso  (flash_miso),
    .dsp_busy    (dsp_busy),
    .cpu_busy    (cpu_busy),
    .dsp_fault   (dsp_fault),
    .cpu_fault   (cpu_fault)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner 0=none 1=DSP 2=CPU; gap = guard cycles left; histories hold
  // raw CS samples taken at each edge since reset, newest first.
  int m_owner, m_gap, m_held, m_last;
  bit m_lock_d, m_lock_c, m_fault_d, m_fault_c, m_bd, m_bc;
  bit hist_d[$], hist_c[$];

  task automatic m_reset();
    m_owner = 0; m_gap = 0; m_held = 0; m_last = 2;
    m_lock_d = 0; m_lock_c = 0; m_fault_d = 0; m_fault_c = 0;
    m_bd = 0; m_bc = 0;
    hist_d.delete(); hist_c.delete();
  endtask

  task automatic m_deny(input int who);
    if (who == 1) begin m_fault_d = 1; m_lock_d = 1; end
    else          begin m_fault_c = 1; m_lock_c = 1; end
  endtask

  always @(posedge sysclk) begin
    if (!reset_INV) begin
      m_reset();
    end else begin
      bit sd, sc, fd, fc, nbd, nbc, own_hi;
      // synchronised CS is the raw value sampled two edges earlier
      sd  = (hist_d.size() >= 2) ? hist_d[1] : 1'b1;
      sc  = (hist_c.size() >= 2) ? hist_c[1] : 1'b1;
      fd  = (hist_d.size() >= 3) && hist_d[2] && !hist_d[1] && dsp_en && !m_lock_d;
      fc  = (hist_c.size() >= 3) && hist_c[2] && !hist_c[1] && !m_lock_c;
      nbd = (m_owner == 2) || (m_gap > 0);
      nbc = (m_owner == 1) || (m_gap > 0);
      if (sd) m_lock_d = 0;
      if (sc) m_lock_c = 0;
      if (m_owner == 0 && m_gap == 0) begin
        m_held = 0;
        if (fd && fc) begin
          m_owner = (m_last == 2) ? 1 : 2;
          m_deny(3 - m_owner);
        end else if (fd) m_owner = 1;
        else if (fc) m_owner = 2;
      end else if (m_owner != 0) begin
        if (m_owner == 1 && fc) m_deny(2);
        if (m_owner == 2 && fd) m_deny(1);
        own_hi = (m_owner == 1) ? sd : sc;
        if (own_hi) begin
          m_last = m_owner; m_owner = 0; m_gap = GUARD;
        end else if (m_held + 1 >= HOLD || (m_owner == 1 && !dsp_en)) begin
          m_deny(m_owner);
          m_last = m_owner; m_owner = 0; m_gap = GUARD;
        end else begin
          m_held++;
        end
      end else begin
        if (fd) m_deny(1);
        if (fc) m_deny(2);
        m_gap--;
      end
      m_bd = nbd;
      m_bc = nbc;
      hist_d.push_front(dsp_cs_INV);
      hist_c.push_front(cpu_cs_INV);
      if (hist_d.size() > 4) void'(hist_d.pop_back());
      if (hist_c.size() > 4) void'(hist_c.pop_back());
    end
  end

  always @(posedge sysclk) begin
    #1;
    chk("m_flash_cs",   flash_cs_INV, (m_owner == 1) ? dsp_cs_INV : (m_owner == 2) ? cpu_cs_INV : 1'b1);
    chk("m_flash_clk",  flash_clk,    (m_owner == 1) ? dsp_clk    : (m_owner == 2) ? cpu_clk    : 1'b0);
    chk("m_flash_mosi", flash_mosi,   (m_owner == 1) ? dsp_mosi   : (m_owner == 2) ? cpu_mosi   : 1'b0);
    chk("m_dsp_miso",   dsp_miso,     (m_owner == 1) ? flash_miso : 1'b0);
    chk("m_cpu_miso",   cpu_miso,     (m_owner == 2) ? flash_miso : 1'b0);
    chk("m_dsp_busy",   dsp_busy,     m_bd | ~dsp_en);
    chk("m_cpu_busy",   cpu_busy,     m_bc);
    chk("m_dsp_fault",  dsp_fault,    m_fault_d);
    chk("m_cpu_fault",  cpu_fault,    m_fault_c);
  end

  task automatic step(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic at_edge(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic idle_pins();
    dsp_cs_INV = 1; dsp_clk = 0; dsp_mosi = 0;
    cpu_cs_INV = 1; cpu_clk = 0; cpu_mosi = 0;
    flash_miso = 0; dsp_en = 1;
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    reset_INV = 0;
    idle_pins();
    step(3);
    reset_INV = 1;
    step(5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_INV = 0;
    idle_pins();
    step(2);
    chk("rst_flash_cs", flash_cs_INV, 1'b1);
    chk("rst_dsp_busy", dsp_busy, 1'b0);
    chk("rst_faults",   dsp_fault | cpu_fault, 1'b0);

    // DSP alone: grant on the third edge, guard of 4, busy lags state by one
    do_reset();
    dsp_cs_INV = 0;
    at_edge(2);
    chk("t1_no_grant_e2", flash_cs_INV, 1'b1);
    at_edge(1);
    chk("t1_grant_e3", flash_cs_INV, 1'b0);
    chk("t1_busy_lag", cpu_busy, 1'b0);
    at_edge(1);
    chk("t1_cpu_busy", cpu_busy, 1'b1);
    step(1);
    dsp_clk = 1; dsp_mosi = 1; flash_miso = 1;
    #1;
    chk("t1_flash_clk",  flash_clk, 1'b1);
    chk("t1_flash_mosi", flash_mosi, 1'b1);
    chk("t1_dsp_miso",   dsp_miso, 1'b1);
    chk("t1_cpu_miso",   cpu_miso, 1'b0);
    step(3);
    dsp_clk = 0; dsp_mosi = 0; flash_miso = 0; dsp_cs_INV = 1;
    at_edge(7);
    chk("t1_guard_busy", cpu_busy, 1'b1);
    at_edge(1);
    chk("t1_busy_clear", cpu_busy, 1'b0);
    chk("t1_no_fault", dsp_fault | cpu_fault, 1'b0);

    // Tie after reset goes to DSP, then round-robin gives CPU the next tie
    do_reset();
    dsp_cs_INV = 0; cpu_cs_INV = 0; cpu_clk = 1;
    at_edge(3);
    chk("t2_dsp_wins", flash_clk, 1'b0);
    chk("t2_owned",    flash_cs_INV, 1'b0);
    chk("t2_cpu_fault", cpu_fault, 1'b1);
    chk("t2_dsp_clean", dsp_fault, 1'b0);
    step(2);
    dsp_cs_INV = 1; cpu_cs_INV = 1; cpu_clk = 0;
    step(10);
    dsp_cs_INV = 0; cpu_cs_INV = 0; cpu_clk = 1;
    at_edge(3);
    chk("t2_rr_cpu", flash_clk, 1'b1);
    chk("t2_dsp_fault", dsp_fault, 1'b1);
    step(2);
    idle_pins();
    step(10);

    // DSP denied while CPU owns, stays locked out until it re-raises CS
    do_reset();
    cpu_cs_INV = 0;
    at_edge(3);
    chk("t3_cpu_owns", flash_cs_INV, 1'b0);
    step(1);
    dsp_cs_INV = 0;
    at_edge(2);
    chk("t3_fault_pending", dsp_fault, 1'b0);
    at_edge(1);
    chk("t3_dsp_fault", dsp_fault, 1'b1);
    chk("t3_dsp_busy",  dsp_busy, 1'b1);
    step(2);
    cpu_cs_INV = 1;
    step(12);
    at_edge(1);
    chk("t3_dsp_locked", flash_cs_INV, 1'b1);
    step(1);
    dsp_cs_INV = 1;
    step(3);
    dsp_cs_INV = 0;
    at_edge(3);
    chk("t3_dsp_regrant", flash_cs_INV, 1'b0);
    chk("t3_cpu_clean", cpu_fault, 1'b0);
    step(1);
    idle_pins();
    step(10);

    // CPU hold timeout: owns exactly 16 cycles, then forced off
    do_reset();
    cpu_cs_INV = 0;
    at_edge(18);
    chk("t4_owned_c16", flash_cs_INV, 1'b0);
    chk("t4_no_fault_yet", cpu_fault, 1'b0);
    at_edge(1);
    chk("t4_forced", flash_cs_INV, 1'b1);
    chk("t4_cpu_fault", cpu_fault, 1'b1);
    step(20);
    at_edge(1);
    chk("t4_no_regrant", flash_cs_INV, 1'b1);
    step(1);
    cpu_cs_INV = 1;
    step(10);
    at_edge(1);
    chk("t4_sticky", cpu_fault, 1'b1);

    // dsp_en falling forces the DSP off; DSP edges are ignored while disabled
    do_reset();
    dsp_cs_INV = 0;
    at_edge(3);
    chk("t5_dsp_owns", flash_cs_INV, 1'b0);
    step(1);
    dsp_en = 0;
    at_edge(1);
    chk("t5_en_drop", flash_cs_INV, 1'b1);
    chk("t5_dsp_fault", dsp_fault, 1'b1);
    chk("t5_dsp_busy", dsp_busy, 1'b1);
    step(1);
    dsp_cs_INV = 1;
    step(3);
    dsp_cs_INV = 0;
    step(8);
    at_edge(1);
    chk("t5_dsp_ignored", flash_cs_INV, 1'b1);
    step(1);
    cpu_cs_INV = 0; cpu_clk = 1;
    at_edge(3);
    chk("t5_cpu_grant", flash_clk, 1'b1);
    chk("t5_cpu_clean", cpu_fault, 1'b0);
    step(1);
    idle_pins();
    step(10);

    // Reset during CPU ownership: CS released at once, no grant on held-low CS
    do_reset();
    cpu_cs_INV = 0;
    at_edge(3);
    step(1);
    dsp_cs_INV = 0;
    at_edge(3);
    chk("t6_dsp_fault", dsp_fault, 1'b1);
    step(1);
    reset_INV = 0;
    #1;
    chk("t6_async_cs", flash_cs_INV, 1'b1);
    chk("t6_fault_clr", dsp_fault, 1'b0);
    step(3);
    reset_INV = 1;
    step(12);
    at_edge(1);
    chk("t6_no_grant", flash_cs_INV, 1'b1);
    step(1);
    idle_pins();
    step(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
